// File: rtl/nios_system_sound_pkg.sv
// Shared constants, state encoding and sizing helper for the sound sequencer.
package nios_system_sound_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_CONTROL = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_CLEAR    = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int STAT_EMPTY    = 16;
  localparam int STAT_FULL     = 17;
  localparam int STAT_UNDERRUN = 18;
  localparam int STAT_OVERFLOW = 19;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  // Level must be able to represent a completely full FIFO, hence the +1.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nios_system_sound_sequencer_if.sv
// Avalon-MM slave bus bundle for the sound sequencer register file.
interface nios_system_sound_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, read_n, writedata,
                  input  readdata);
  modport slave  (input  address, chipselect, write_n, read_n, writedata,
                  output readdata);
endinterface

// File: rtl/nios_system_sound_fifo.sv
// Synchronous sample FIFO; pointers wrap naturally, occupancy kept in its own counter.
module nios_system_sound_fifo
  import nios_system_sound_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LW         = level_w(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clear,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/nios_system_sound_sequencer.sv
// Avalon-MM sample pacer: CPU fills a FIFO, a PERIOD+1 clock divider drains it to out_port.
module nios_system_sound_sequencer
  import nios_system_sound_pkg::*;
#(
  parameter int FIFO_DEPTH     = 64,
  parameter int DEFAULT_PERIOD = 1041,
  parameter int DATA_W         = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  nios_system_sound_sequencer_if.slave  avs,
  output logic [DATA_W-1:0]             out_port,
  output logic                          sample_strobe,
  output logic                          irq
);

  localparam int          LW         = level_w(FIFO_DEPTH);
  localparam logic [15:0] RST_PERIOD = 16'(DEFAULT_PERIOD);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       period_q, period_d;
  logic              enable_q, enable_d;
  logic              irq_en_q, irq_en_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              strobe_q, strobe_d;
  logic              underrun_q, underrun_d;
  logic              overflow_q, overflow_d;
  logic              irq_q, irq_d;

  logic              wr, rd;
  logic              wr_data, wr_ctrl, wr_period, wr_status;
  logic              clear, tick, pop;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic [LW-1:0]     fifo_level;
  logic [31:0]       rdata;
  logic              unused_wd;

  assign wr        = avs.chipselect & ~avs.write_n;
  assign rd        = avs.chipselect & ~avs.read_n;
  assign wr_data   = wr && (avs.address == ADDR_DATA);
  assign wr_ctrl   = wr && (avs.address == ADDR_CONTROL);
  assign wr_period = wr && (avs.address == ADDR_PERIOD);
  assign wr_status = wr && (avs.address == ADDR_STATUS);
  assign clear     = wr_ctrl & avs.writedata[CTRL_CLEAR];
  assign unused_wd = &{1'b0, avs.writedata[31:20]};

  // CLEAR suppresses the tick outright so a coinciding pop never strobes.
  assign tick = (state_q == PLAY) && enable_q && (cnt_q == '0) && !clear;
  assign pop  = tick & ~fifo_empty;

  nios_system_sound_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LW         (LW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_data),
    .push_data (avs.writedata[DATA_W-1:0]),
    .pop       (pop),
    .clear     (clear),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = period_q;
        if (enable_q) state_d = PLAY;
      end
      PLAY: begin
        if (!enable_q || clear) begin
          state_d = IDLE;
          cnt_d   = period_q;
        end else if (cnt_q == '0) begin
          cnt_d = period_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    period_d   = period_q;
    out_d      = out_q;
    strobe_d   = pop;
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    if (wr_ctrl) begin
      enable_d = avs.writedata[CTRL_ENABLE];
      irq_en_d = avs.writedata[CTRL_IRQ_EN];
    end
    if (wr_period) period_d = avs.writedata[15:0];
    if (pop)       out_d    = fifo_head;
    // Clear first, then set, so a coinciding event keeps the flag.
    if (wr_status && avs.writedata[STAT_UNDERRUN]) underrun_d = 1'b0;
    if (wr_status && avs.writedata[STAT_OVERFLOW]) overflow_d = 1'b0;
    if (tick && fifo_empty)   underrun_d = 1'b1;
    if (wr_data && fifo_full) overflow_d = 1'b1;
    irq_d = irq_en_q & enable_q & (fifo_level <= LW'(FIFO_DEPTH / 2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= RST_PERIOD;
      period_q   <= RST_PERIOD;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      out_q      <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      out_q      <= out_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (avs.address)
        ADDR_DATA:    rdata[DATA_W-1:0] = out_q;
        ADDR_CONTROL: begin
          rdata[CTRL_ENABLE] = enable_q;
          rdata[CTRL_IRQ_EN] = irq_en_q;
        end
        ADDR_PERIOD:  rdata[15:0] = period_q;
        ADDR_STATUS:  begin
          rdata[LW-1:0]        = fifo_level;
          rdata[STAT_EMPTY]    = fifo_empty;
          rdata[STAT_FULL]     = fifo_full;
          rdata[STAT_UNDERRUN] = underrun_q;
          rdata[STAT_OVERFLOW] = overflow_q;
        end
        default: rdata = '0;
      endcase
    end
  end

  assign avs.readdata  = rdata;
  assign out_port      = out_q;
  assign sample_strobe = strobe_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_nios_system_sound_sequencer.sv
// Directed bench for the sound sequencer: registers, pacing, FIFO limits, irq, clear and reset.
module tb_nios_system_sound_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] out_port;
  logic        sample_strobe;
  logic        irq;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rdv;

  always #5 clk = ~clk;

  nios_system_sound_sequencer_if bus ();

  nios_system_sound_sequencer #(
    .FIFO_DEPTH     (64),
    .DEFAULT_PERIOD (1041),
    .DATA_W         (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avs           (bus.slave),
    .out_port      (out_port),
    .sample_strobe (sample_strobe),
    .irq           (irq)
  );

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
    #1 d = bus.readdata;
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
  endtask

  task automatic prep();
    bus_write(2'd1, 32'h2);
    bus_write(2'd3, 32'h000C_0000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_read(2'd0, rdv);
    n_checks++; if (rdv !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want %h", rdv, 32'h0); end
    @(negedge clk); bus_read(2'd1, rdv);
    n_checks++; if (rdv !== 32'h0) begin n_fail++; $display("FAIL reset_control got %h want %h", rdv, 32'h0); end
    @(negedge clk); bus_read(2'd2, rdv);
    n_checks++; if (rdv !== 32'd1041) begin n_fail++; $display("FAIL reset_period got %h want %h", rdv, 32'd1041); end
    @(negedge clk); bus_read(2'd3, rdv);
    n_checks++; if (rdv !== 32'h0001_0000) begin n_fail++; $display("FAIL reset_status got %h want %h", rdv, 32'h0001_0000); end
    n_checks++; if (out_port !== 16'h0 || sample_strobe !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs got out=%h strobe=%b irq=%b want 0/0/0", out_port, sample_strobe, irq);
    end
  endtask

  task automatic test_playback();
    int k;
    int seen;
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'h1111);
    bus_write(2'd0, 32'h2222);
    bus_write(2'd1, 32'h1);
    k = 0;
    for (int i = 1; i <= 20; i++) begin @(negedge clk); if (sample_strobe) begin k = i; break; end end
    n_checks++; if (k !== 5) begin n_fail++; $display("FAIL play_first_gap got %0d want 5", k); end
    n_checks++; if (out_port !== 16'h1111) begin n_fail++; $display("FAIL play_first_sample got %h want 1111", out_port); end
    k = 0;
    for (int i = 1; i <= 20; i++) begin @(negedge clk); if (sample_strobe) begin k = i; break; end end
    n_checks++; if (k !== 4) begin n_fail++; $display("FAIL play_second_gap got %0d want 4", k); end
    n_checks++; if (out_port !== 16'h2222) begin n_fail++; $display("FAIL play_second_sample got %h want 2222", out_port); end
    seen = 0;
    for (int i = 1; i <= 7; i++) begin @(negedge clk); if (sample_strobe) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL play_underrun_strobe got %0d strobes want 0", seen); end
    bus_read(2'd3, rdv);
    n_checks++; if (rdv !== 32'h0005_0000) begin n_fail++; $display("FAIL play_underrun_status got %h want %h", rdv, 32'h0005_0000); end
    n_checks++; if (out_port !== 16'h2222) begin n_fail++; $display("FAIL play_hold_sample got %h want 2222", out_port); end
  endtask

  task automatic test_overflow();
    int cnt;
    int bad;
    prep();
    for (int i = 0; i < 65; i++) bus_write(2'd0, 32'h100 + i);
    bus_read(2'd3, rdv);
    n_checks++; if (rdv !== 32'h000A_0040) begin n_fail++; $display("FAIL ovf_status got %h want %h", rdv, 32'h000A_0040); end
    bus_write(2'd2, 32'd0);
    bus_write(2'd1, 32'h1);
    cnt = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sample_strobe) begin
        if (out_port !== 16'(32'h100 + cnt)) bad++;
        cnt++;
      end
    end
    n_checks++; if (cnt !== 64) begin n_fail++; $display("FAIL ovf_drain_count got %0d want 64", cnt); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ovf_drain_order got %0d wrong samples want 0", bad); end
    n_checks++; if (out_port !== 16'h013F) begin n_fail++; $display("FAIL ovf_last_sample got %h want 013f", out_port); end
    bus_write(2'd1, 32'h0);
    bus_read(2'd3, rdv);
    n_checks++; if (rdv !== 32'h000D_0000) begin n_fail++; $display("FAIL ovf_sticky got %h want %h", rdv, 32'h000D_0000); end
    bus_write(2'd3, 32'h000C_0000);
    bus_read(2'd3, rdv);
    n_checks++; if (rdv !== 32'h0001_0000) begin n_fail++; $display("FAIL ovf_sticky_clear got %h want %h", rdv, 32'h0001_0000); end
  endtask

  task automatic test_irq();
    int a;
    int b;
    logic irq_at_a;
    int lvl;
    prep();
    bus_write(2'd2, 32'd0);
    for (int i = 0; i < 40; i++) bus_write(2'd0, 32'h300 + i);
    bus_write(2'd1, 32'h5);
    a = -1; b = -1; irq_at_a = 1'bx;
    bus.address = 2'd3; bus.chipselect = 1'b1; bus.read_n = 1'b0;
    for (int i = 1; i <= 60 && b < 0; i++) begin
      @(negedge clk); #1;
      if (a < 0 && bus.readdata[10:0] == 11'd32) begin a = i; irq_at_a = irq; end
      if (b < 0 && irq) b = i;
    end
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
    n_checks++; if (irq_at_a !== 1'b0) begin n_fail++; $display("FAIL irq_lag got irq=%b at level 32 want 0", irq_at_a); end
    n_checks++; if (a < 0 || b !== a + 1) begin n_fail++; $display("FAIL irq_rise got cycle %0d want %0d", b, a + 1); end
    bus_write(2'd2, 32'd1000);
    @(negedge clk);
    bus_read(2'd3, rdv);
    lvl = int'(rdv[10:0]);
    for (int i = lvl; i < 32; i++) bus_write(2'd0, 32'h400 + i);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_high_at_32 got %b want 1", irq); end
    bus_write(2'd0, 32'h4FF);
    bus_read(2'd3, rdv);
    n_checks++; if (rdv[10:0] !== 11'd33 || irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_fall_lag got level=%0d irq=%b want 33/1", rdv[10:0], irq);
    end
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall got %b want 0", irq); end
  endtask

  task automatic test_back_to_back();
    prep();
    bus_write(2'd2, 32'd3);
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'hA0 + i);
    bus_write(2'd1, 32'h1);
    repeat (3) @(negedge clk);
    bus_write(2'd0, 32'hA5);
    n_checks++; if (sample_strobe !== 1'b1 || out_port !== 16'h00A0) begin
      n_fail++; $display("FAIL b2b_pop got strobe=%b out=%h want 1/00a0", sample_strobe, out_port);
    end
    bus_read(2'd3, rdv);
    n_checks++; if (rdv !== 32'h0000_0005) begin n_fail++; $display("FAIL b2b_level got %h want %h", rdv, 32'h5); end
    repeat (2) @(negedge clk);
    bus_write(2'd1, 32'h3);
    n_checks++; if (sample_strobe !== 1'b0 || out_port !== 16'h00A0) begin
      n_fail++; $display("FAIL clear_tick got strobe=%b out=%h want 0/00a0", sample_strobe, out_port);
    end
    bus_read(2'd3, rdv);
    n_checks++; if (rdv !== 32'h0001_0000) begin n_fail++; $display("FAIL clear_status got %h want %h", rdv, 32'h0001_0000); end
  endtask

  task automatic test_reset_mid_play();
    prep();
    bus_write(2'd2, 32'd3);
    for (int i = 0; i < 10; i++) bus_write(2'd0, 32'hB0 + i);
    bus_write(2'd1, 32'h1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (sample_strobe !== 1'b0 || out_port !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid_out got strobe=%b out=%h want 0/0000", sample_strobe, out_port);
    end
    bus_read(2'd3, rdv);
    n_checks++; if (rdv !== 32'h0001_0000) begin n_fail++; $display("FAIL rst_mid_status got %h want %h", rdv, 32'h0001_0000); end
    @(negedge clk); bus_read(2'd2, rdv);
    n_checks++; if (rdv !== 32'd1041) begin n_fail++; $display("FAIL rst_mid_period got %h want %h", rdv, 32'd1041); end
    @(negedge clk); bus_read(2'd1, rdv);
    n_checks++; if (rdv !== 32'h0) begin n_fail++; $display("FAIL rst_mid_control got %h want 0", rdv); end
    repeat (8) @(negedge clk);
    n_checks++; if (sample_strobe !== 1'b0 || out_port !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid_idle got strobe=%b out=%h want 0/0000", sample_strobe, out_port);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.read_n = 1'b1; bus.writedata = 32'h0;
    test_reset();
    test_playback();
    test_overflow();
    test_irq();
    test_back_to_back();
    test_reset_mid_play();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_system_sound_sequencer.md
Name: nios_system_sound_sequencer

Overview:
Avalon-MM slave that paces audio samples out to the 16-bit sound output at a programmed sample rate. The Nios II writes samples into an internal FIFO. A clock-divider tick pops one sample per period and drives it to the output port. An interrupt tells software to refill the FIFO, and sticky flags record underrun and overflow. This block replaces direct CPU writes to the sound PIO, so sample timing does not depend on software jitter.

Parameters:
FIFO_DEPTH, 64, sample FIFO entries; power of 2, range 4..1024
DEFAULT_PERIOD, 1041, reset value of PERIOD; 50 MHz / (1041+1) ≈ 48 kHz
DATA_W, 16, sample width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
read_n  in  1  active-low read strobe; reads have no side effects
writedata  in  32  write data
readdata  out  32  combinational read data, zero wait states
out_port  out  DATA_W  current sample
sample_strobe  out  1  one-cycle pulse when out_port updates
irq  out  1  level interrupt

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Register map (word addresses):
  - 0 DATA: write pushes writedata[15:0]; read returns out_port zero-extended.
  - 1 CONTROL: bit0 ENABLE, bit1 CLEAR (self-clearing, reads 0), bit2 IRQ_EN.
  - 2 PERIOD: bits[15:0].
  - 3 STATUS: bits[10:0] LEVEL, bit16 EMPTY, bit17 FULL, bit18 UNDERRUN, bit19 OVERFLOW.
- STATUS write: a 1 in bit18 or bit19 clears that sticky flag. All other STATUS bits are read-only.
- Reset values:
  - out_port=0, sample_strobe=0, irq=0.
  - ENABLE=0, IRQ_EN=0, PERIOD=DEFAULT_PERIOD.
  - FIFO empty, sticky flags 0, state IDLE, tick counter=DEFAULT_PERIOD.
- FSM, two states:
  - IDLE: counter held at PERIOD.
  - IDLE→PLAY when ENABLE is 1. The counter reloads on entry.
  - PLAY→IDLE when ENABLE is 0 or CLEAR is written.
- Tick generation in PLAY:
  - Counter decrements each clk. At 0 a tick fires and the counter reloads PERIOD.
  - Tick interval is PERIOD+1 clocks. PERIOD=0 gives a tick every clock.
  - First tick occurs PERIOD+1 clocks after entering PLAY.
  - A PERIOD write takes effect at the next reload; the current count is not disturbed.
- On tick:
  - FIFO non-empty: pop the head. out_port=head on the next edge, with sample_strobe high that same cycle.
  - FIFO empty: out_port holds, no strobe, UNDERRUN<=1.
- out_port retains its last value in IDLE. Only reset zeroes it.
- DATA write:
  - Pushes when FIFO is not full, with fullness evaluated before the cycle.
  - When full, the write is dropped and OVERFLOW<=1. This holds even if a pop occurs the same cycle.
- Simultaneous push and pop (non-full, non-empty): both occur, LEVEL unchanged.
- Push into an empty FIFO on a tick cycle: the tick sees it empty, so UNDERRUN is set and the pushed sample is retained.
- CLEAR:
  - Empties the FIFO (LEVEL=0) and reloads the counter.
  - Wins over a same-cycle tick pop: no strobe.
  - Does not alter sticky flags or out_port.
- Sticky flag set and clear in the same cycle: set wins.
- irq = IRQ_EN & ENABLE & (LEVEL <= FIFO_DEPTH/2). Registered, one-cycle lag after LEVEL changes.
- Reset asserted mid-playback: all state returns to reset values on that edge, and no strobe is issued.

Decomposition:
- Package nios_system_sound_pkg:
  - Register address constants ADDR_DATA/CONTROL/PERIOD/STATUS.
  - CONTROL and STATUS bit positions.
  - FSM state enum {IDLE, PLAY}.
  - Level-field width function clog2(FIFO_DEPTH)+1.
- One sub-module: nios_system_sound_fifo.
  - Synchronous FIFO, DATA_W wide, FIFO_DEPTH deep.
  - Ports: push, pop, clear, full, empty, level.
  - Pointers wrap mod FIFO_DEPTH; level tracked separately.

Test Plan:
- Reset, then read all four registers → DATA=0, CONTROL=0, PERIOD=1041, STATUS=0x00010000 (EMPTY only); out_port=0.
- PERIOD=3, write samples 0x1111, 0x2222, then CONTROL=1 → strobes 4 clocks apart; out_port 0x1111 then 0x2222; the third tick sets UNDERRUN; out_port holds 0x2222.
- Write 65 samples with FIFO_DEPTH=64 while disabled → LEVEL=64, FULL=1, OVERFLOW=1; 65th sample absent after draining; STATUS write 0x000C0000 → both stickies clear.
- IRQ_EN|ENABLE with LEVEL=40, PERIOD=0 → irq rises the cycle after LEVEL reaches 32; writing samples to LEVEL 33 → irq falls one cycle later.
- Push on the same cycle as a tick pop with LEVEL=5 → LEVEL stays 5, strobe fires; CLEAR on a tick cycle → LEVEL=0, no strobe, out_port unchanged.
- Assert reset mid-PLAY with LEVEL=10 → next cycle out_port=0, LEVEL=0, IDLE, no strobe; PERIOD returns to 1041.
